// File: rtl/mram_access_sequencer.sv
// Two-requester sequencer for an asynchronous MRAM: round-robin arbitration,
// then setup / strobe / hold phases with programmable cycle counts.
module mram_access_sequencer #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned WR_CYC    = 3,
    parameter int unsigned RD_CYC    = 3,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [19:0] req0_addr,
    input  logic [15:0] req0_wdata,
    input  logic [1:0]  req0_be,
    output logic        req0_ready,
    output logic        req0_rvalid,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [19:0] req1_addr,
    input  logic [15:0] req1_wdata,
    input  logic [1:0]  req1_be,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [15:0] rdata,
    output logic [19:0] addr_out,
    output logic [15:0] data_out,
    output logic        dq_oe,
    input  logic [15:0] data_in,
    output logic        chip_en,
    output logic        write_en,
    output logic        out_en,
    output logic        lower_byte_en,
    output logic        upper_byte_en,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WR_LD    = 4'(WR_CYC - 1);
    localparam logic [3:0] RD_LD    = 4'(RD_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;     // 1 = requester 1 was granted last
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] rdata_q, rdata_d;

    logic        accept;
    logic        gnt_sel;

    // Round-robin pick; acceptance only in IDLE and never while in reset.
    always_comb begin
        gnt_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_sel = ~last_q;
        end else begin
            gnt_sel = req1_valid;
        end
        accept     = rst && (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !gnt_sel;
        req1_ready = accept &&  gnt_sel;
    end

    // Next-state, phase counter and transaction capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    last_d  = gnt_sel;
                    owner_d = gnt_sel;
                    if (gnt_sel) begin
                        wr_d    = req1_write;
                        addr_d  = req1_addr;
                        wdata_d = req1_wdata;
                        be_d    = req1_be;
                    end else begin
                        wr_d    = req0_write;
                        addr_d  = req0_addr;
                        wdata_d = req0_wdata;
                        be_d    = req0_be;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = wr_q ? WRITE : READ;
                    cnt_d   = wr_q ? WR_LD : RD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    rdata_d = data_in;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and transaction registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // MRAM control decode from the current phase (controls are active-low).
    always_comb begin
        chip_en       = 1'b1;
        write_en      = 1'b1;
        out_en        = 1'b1;
        lower_byte_en = 1'b1;
        upper_byte_en = 1'b1;
        dq_oe         = 1'b0;
        req0_rvalid   = 1'b0;
        req1_rvalid   = 1'b0;
        case (state_q)
            SETUP: begin
                chip_en       = 1'b0;
                lower_byte_en = ~be_q[0];
                upper_byte_en = ~be_q[1];
                dq_oe         = wr_q;
            end
            WRITE: begin
                chip_en       = 1'b0;
                write_en      = 1'b0;
                lower_byte_en = ~be_q[0];
                upper_byte_en = ~be_q[1];
                dq_oe         = 1'b1;
            end
            READ: begin
                chip_en       = 1'b0;
                out_en        = 1'b0;
                lower_byte_en = ~be_q[0];
                upper_byte_en = ~be_q[1];
            end
            HOLD: begin
                chip_en       = 1'b0;
                lower_byte_en = ~be_q[0];
                upper_byte_en = ~be_q[1];
                dq_oe         = wr_q;
                // The counter still holds its load value only in the first HOLD cycle.
                if (!wr_q && (cnt_q == HOLD_LD)) begin
                    req0_rvalid = !owner_q;
                    req1_rvalid = owner_q;
                end
            end
            default: begin
                chip_en = 1'b1;
            end
        endcase
        busy     = (state_q != IDLE);
        addr_out = addr_q;
        data_out = wdata_q;
        rdata    = rdata_q;
    end

endmodule

// File: tb/tb_mram_access_sequencer.sv
// Directed bench for mram_access_sequencer: default instance plus one with
// SETUP_CYC=2, WR_CYC=1, HOLD_CYC=3; read results go through a scoreboard.
module tb_mram_access_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Default-parameter instance
    logic        req0_valid, req0_write, req0_ready, req0_rvalid;
    logic [19:0] req0_addr;
    logic [15:0] req0_wdata;
    logic [1:0]  req0_be;
    logic        req1_valid, req1_write, req1_ready, req1_rvalid;
    logic [19:0] req1_addr;
    logic [15:0] req1_wdata;
    logic [1:0]  req1_be;
    logic [15:0] rdata, data_out, data_in;
    logic [19:0] addr_out;
    logic        dq_oe, chip_en, write_en, out_en, lower_byte_en, upper_byte_en, busy;

    // Parameterised instance
    logic        p_req0_valid, p_req0_write, p_req0_ready, p_req0_rvalid;
    logic [19:0] p_req0_addr;
    logic [15:0] p_req0_wdata;
    logic [1:0]  p_req0_be;
    logic        p_req1_valid, p_req1_write, p_req1_ready, p_req1_rvalid;
    logic [19:0] p_req1_addr;
    logic [15:0] p_req1_wdata;
    logic [1:0]  p_req1_be;
    logic [15:0] p_rdata, p_data_out, p_data_in;
    logic [19:0] p_addr_out;
    logic        p_dq_oe, p_chip_en, p_write_en, p_out_en, p_lower_byte_en, p_upper_byte_en, p_busy;

    mram_access_sequencer dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .rdata(rdata), .addr_out(addr_out), .data_out(data_out), .dq_oe(dq_oe), .data_in(data_in),
        .chip_en(chip_en), .write_en(write_en), .out_en(out_en),
        .lower_byte_en(lower_byte_en), .upper_byte_en(upper_byte_en), .busy(busy)
    );

    mram_access_sequencer #(.SETUP_CYC(2), .WR_CYC(1), .RD_CYC(3), .HOLD_CYC(3)) dut_p (
        .clk(clk), .rst(rst),
        .req0_valid(p_req0_valid), .req0_write(p_req0_write), .req0_addr(p_req0_addr),
        .req0_wdata(p_req0_wdata), .req0_be(p_req0_be), .req0_ready(p_req0_ready), .req0_rvalid(p_req0_rvalid),
        .req1_valid(p_req1_valid), .req1_write(p_req1_write), .req1_addr(p_req1_addr),
        .req1_wdata(p_req1_wdata), .req1_be(p_req1_be), .req1_ready(p_req1_ready), .req1_rvalid(p_req1_rvalid),
        .rdata(p_rdata), .addr_out(p_addr_out), .data_out(p_data_out), .dq_oe(p_dq_oe), .data_in(p_data_in),
        .chip_en(p_chip_en), .write_en(p_write_en), .out_en(p_out_en),
        .lower_byte_en(p_lower_byte_en), .upper_byte_en(p_upper_byte_en), .busy(p_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        owner;
        logic [15:0] data;
    } rd_exp_t;
    rd_exp_t sb_q[$];
    rd_exp_t sb_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rvalid pops the oldest expected read.
    always @(negedge clk) begin
        if (req0_rvalid || req1_rvalid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_rvalid_both", {31'd0, req0_rvalid & req1_rvalid}, 32'd0);
                chk("sb_owner", {31'd0, req1_rvalid}, {31'd0, sb_e.owner});
                chk("sb_rdata", {16'd0, rdata}, {16'd0, sb_e.data});
            end
        end
        chk("p_no_rvalid", {30'd0, p_req0_rvalid, p_req1_rvalid}, 32'd0);
    end

    // Strobe safety and grant exclusivity on both instances.
    always @(negedge clk) begin
        chk("inv_we_oe", {31'd0, !write_en && !out_en}, 32'd0);
        chk("inv_strobe_ce", {31'd0, chip_en && (!write_en || !out_en)}, 32'd0);
        chk("inv_ready_excl", {31'd0, req0_ready && req1_ready}, 32'd0);
        chk("p_inv_we_oe", {31'd0, !p_write_en && !p_out_en}, 32'd0);
        chk("p_inv_strobe_ce", {31'd0, p_chip_en && (!p_write_en || !p_out_en)}, 32'd0);
    end

    int exp_owner, last_g, ngrant, rd_setup, we_low;

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_be = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_be = '0;
        data_in = '0;
        p_req0_valid = 1'b0; p_req0_write = 1'b0; p_req0_addr = '0; p_req0_wdata = '0; p_req0_be = '0;
        p_req1_valid = 1'b0; p_req1_write = 1'b0; p_req1_addr = '0; p_req1_wdata = '0; p_req1_be = '0;
        p_data_in = '0;

        // Reset values, with a request pending that must not be acknowledged
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ctrl", {27'd0, chip_en, write_en, out_en, lower_byte_en, upper_byte_en}, 32'h1F);
        chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_addr", {12'd0, addr_out}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // Single write from requester 0
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 20'h00005; req0_wdata = 16'hA5A5; req0_be = 2'b11;
        @(negedge clk);
        chk("w_ready0", {31'd0, req0_ready}, 32'd1);
        chk("w_ready1", {31'd0, req1_ready}, 32'd0);
        chk("w_idle_ce", {31'd0, chip_en}, 32'd1);
        @(posedge clk); #1 req0_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("w_ce", {31'd0, chip_en}, (c <= 5) ? 32'd0 : 32'd1);
            chk("w_we", {31'd0, write_en}, (c >= 2 && c <= 4) ? 32'd0 : 32'd1);
            chk("w_oe", {31'd0, out_en}, 32'd1);
            chk("w_dq_oe", {31'd0, dq_oe}, (c <= 5) ? 32'd1 : 32'd0);
            chk("w_busy", {31'd0, busy}, (c <= 5) ? 32'd1 : 32'd0);
            if (c <= 5) begin
                chk("w_addr", {12'd0, addr_out}, 32'h00005);
                chk("w_data", {16'd0, data_out}, 32'hA5A5);
                chk("w_be", {30'd0, upper_byte_en, lower_byte_en}, 32'd0);
            end
        end

        // Single read from requester 1, lower byte only, inputs disturbed mid-transaction
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 20'hFFFFF; req1_be = 2'b01;
        data_in = 16'h1234;
        sb_q.push_back('{owner: 1'b1, data: 16'h1234});
        @(negedge clk);
        chk("r_ready1", {31'd0, req1_ready}, 32'd1);
        chk("r_ready0", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #1 req1_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("r_oe", {31'd0, out_en}, (c >= 2 && c <= 4) ? 32'd0 : 32'd1);
            chk("r_we", {31'd0, write_en}, 32'd1);
            chk("r_dq_oe", {31'd0, dq_oe}, 32'd0);
            chk("r_rvalid1", {31'd0, req1_rvalid}, (c == 5) ? 32'd1 : 32'd0);
            if (c <= 5) begin
                chk("r_addr", {12'd0, addr_out}, 32'hFFFFF);
                chk("r_be", {30'd0, upper_byte_en, lower_byte_en}, 32'd2);
            end else begin
                chk("r_idle_be", {30'd0, upper_byte_en, lower_byte_en}, 32'd3);
            end
            if (c >= 5) chk("r_rdata", {16'd0, rdata}, 32'h1234);
            if (c == 2) begin
                req1_addr = 20'h00000;
                req1_be = 2'b11;
            end
            if (c == 5) data_in = 16'hDEAD;
        end

        // Contention after reset: grants alternate starting with requester 0
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 20'h00100; req0_wdata = 16'h1111; req0_be = 2'b10;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 20'h00200; req1_be = 2'b00;
        data_in = 16'hBEEF;
        exp_owner = 0; last_g = -1; ngrant = 0; rd_setup = -1;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            if (c == rd_setup) begin
                chk("rr_be00", {30'd0, upper_byte_en, lower_byte_en}, 32'd3);
                chk("rr_be00_ce", {31'd0, chip_en}, 32'd0);
            end
            if (req0_ready || req1_ready) begin
                chk("rr_owner", {31'd0, req1_ready}, exp_owner[31:0]);
                if (last_g >= 0) chk("rr_spacing", c - last_g, 32'd6);
                if (req1_ready) begin
                    sb_q.push_back('{owner: 1'b1, data: 16'hBEEF});
                    rd_setup = c + 1;
                end
                exp_owner = exp_owner ^ 1;
                last_g = c;
                ngrant++;
            end
        end
        chk("rr_grants", ngrant, 32'd5);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("rr_sb_drained", sb_q.size(), 32'd0);

        // Reset during WRITE; requester 0 granted last, yet wins first after release
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 20'h0ABCD; req0_wdata = 16'h5A5A; req0_be = 2'b11;
        @(negedge clk);
        chk("ar_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("ar_pre_we", {31'd0, write_en}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ar_ctrl", {27'd0, chip_en, write_en, out_en, lower_byte_en, upper_byte_en}, 32'h1F);
        chk("ar_dq_oe", {31'd0, dq_oe}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_addr", {12'd0, addr_out}, 32'd0);
        chk("ar_data_out", {16'd0, data_out}, 32'd0);
        chk("ar_rdata", {16'd0, rdata}, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1; req1_be = 2'b11;
        @(negedge clk);
        chk("ar_in_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("ar_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Parameterised instance: 1-cycle write strobe, 7-cycle accept spacing
        p_req0_valid = 1'b1; p_req0_write = 1'b1; p_req0_addr = 20'h12345; p_req0_wdata = 16'hC3C3; p_req0_be = 2'b11;
        we_low = 0;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            chk("p_ready", {31'd0, p_req0_ready}, (c % 7 == 0) ? 32'd1 : 32'd0);
            chk("p_we", {31'd0, p_write_en}, (c % 7 == 3) ? 32'd0 : 32'd1);
            chk("p_ce", {31'd0, p_chip_en}, (c % 7 == 0) ? 32'd1 : 32'd0);
            if (c <= 6 && !p_write_en) we_low++;
        end
        chk("p_we_width", we_low, 32'd1);
        @(posedge clk); #1 p_req0_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("end_sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
